// File: rtl/crg_seq.sv
// Clock-enable / reset sequencer behind the PLL: lock qualification, staggered
// per-channel reset release, soft-reset pulses and fractional-NCO clock enables.
// Optional lock-loss event counter is built when CRG_LOSS_CNT_EN is defined.
//
// state   | meaning
// HOLD    | all channels in reset, waiting for synchronised lock
// SETTLE  | lock seen, timing the lock-stable window
// RELEASE | releasing channels 1..CHANNELS-1, one per stagger interval
// RUN     | all released; soft-reset requests honoured
module crg_seq #(
  parameter int CHANNELS     = 4,
  parameter int ACC_W        = 32,
  parameter int LOCK_CYCLES  = 1024,
  parameter int STAGGER      = 64,
  parameter int PULSE_CYCLES = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      pll_locked,
  input  logic [CHANNELS*ACC_W-1:0] ce_inc,
  input  logic [CHANNELS-1:0]       chan_rst_req,
  output logic [CHANNELS-1:0]       rst_out,
  output logic [CHANNELS-1:0]       ce_out,
  output logic                      ready,
  output logic [7:0]                lock_loss_cnt
);

  localparam int CNT_MAX = (LOCK_CYCLES > STAGGER) ? LOCK_CYCLES : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int PUL_W   = $clog2(PULSE_CYCLES) + 1;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {HOLD, SETTLE, RELEASE, RUN} state_t;

  state_t             state;
  logic               sync1;
  logic               lock_s;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [PUL_W-1:0]   pcnt [CHANNELS];
  logic [ACC_W-1:0]   acc  [CHANNELS];
  logic [ACC_W:0]     sum  [CHANNELS];
  logic [CHANNELS-1:0] nco_clr;
  logic               lock_drop;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  assign lock_drop = (state != HOLD) && !lock_s;

  // Timers are down-counters loaded with length-1 and acting at zero.
  always_ff @(posedge clk_sys) begin
    if (reset || lock_drop) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) pcnt[i] <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= CNT_W'(LOCK_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rst_out[0] <= 1'b0;
            idx        <= IDX_W'(1);
            cnt        <= CNT_W'(STAGGER - 1);
            if (CHANNELS == 1) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            for (int i = 0; i < CHANNELS; i++)
              if (idx == IDX_W'(i)) rst_out[i] <= 1'b0;
            idx <= idx + 1'b1;
            cnt <= CNT_W'(STAGGER - 1);
            if (idx == IDX_W'(CHANNELS - 1)) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (chan_rst_req[i]) begin
              rst_out[i] <= 1'b1;
              pcnt[i]    <= PUL_W'(PULSE_CYCLES - 1);
            end else if (rst_out[i]) begin
              if (pcnt[i] == '0) rst_out[i] <= 1'b0;
              else               pcnt[i]    <= pcnt[i] - 1'b1;
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  // Clearing on the edge a reset is asserted keeps ce_out silent for the whole pulse.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      nco_clr[i] = rst_out[i] | lock_drop | ((state == RUN) & chan_rst_req[i]);
      sum[i]     = {1'b0, acc[i]} + {1'b0, ce_inc[i*ACC_W +: ACC_W]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_out <= '0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (nco_clr[i]) begin
          acc[i]    <= '0;
          ce_out[i] <= 1'b0;
        end else begin
          acc[i]    <= sum[i][ACC_W-1:0];
          ce_out[i] <= sum[i][ACC_W];
        end
      end
    end
  end

`ifdef CRG_LOSS_CNT_EN
  always_ff @(posedge clk_sys) begin
    if (reset)
      lock_loss_cnt <= '0;
    else if (lock_drop && (lock_loss_cnt != 8'hFF))
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_crg_seq.sv
// Directed bench for crg_seq: release timing, lock glitch/loss, NCO rates,
// soft-reset pulses and synchronous reset mid-sequence.
module tb_crg_seq;

  localparam int CH = 4;
  localparam int AW = 8;
  localparam int LC = 16;
  localparam int ST = 8;
  localparam int PC = 5;
`ifdef CRG_LOSS_CNT_EN
  localparam int LOSS_STEP = 1;
`else
  localparam int LOSS_STEP = 0;
`endif

  logic               clk_sys = 1'b0;
  logic               reset;
  logic               pll_locked;
  logic [CH*AW-1:0]   ce_inc;
  logic [CH-1:0]      chan_rst_req;
  logic [CH-1:0]      rst_out;
  logic [CH-1:0]      ce_out;
  logic               ready;
  logic [7:0]         lock_loss_cnt;

  int n_run  = 0;
  int n_fail = 0;

  crg_seq #(
    .CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LC), .STAGGER(ST), .PULSE_CYCLES(PC)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .ce_inc(ce_inc),
    .chan_rst_req(chan_rst_req), .rst_out(rst_out), .ce_out(ce_out),
    .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n active edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  int cnt0, cnt1, cnt2, cnt3;

  initial begin
    reset        = 1'b1;
    pll_locked   = 1'b0;
    chan_rst_req = '0;
    ce_inc       = {8'd128, 8'd255, 8'd0, 8'd64};
    step(3);
    chk("reset_rst_out", 32'(rst_out), 32'hF);
    chk("reset_ce_out", 32'(ce_out), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_loss", 32'(lock_loss_cnt), 32'h0);
    reset = 1'b0;
    step(3);
    chk("hold_no_lock", 32'(rst_out), 32'hF);

    // Steady lock; next edge is E0.
    pll_locked = 1'b1;
    step(18);
    chk("e17_rst", 32'(rst_out), 32'hF);
    step(1);
    chk("e18_rst", 32'(rst_out), 32'hE);
    chan_rst_req = 4'b0001;
    step(7);
    chk("e25_req_ignored", 32'(rst_out), 32'hE);
    step(1);
    chk("e26_rst", 32'(rst_out), 32'hC);
    step(8);
    chk("e34_rst", 32'(rst_out), 32'h8);
    chan_rst_req = '0;
    step(7);
    chk("e41_rst", 32'(rst_out), 32'h8);
    chk("e41_ready", 32'(ready), 32'h0);
    step(1);
    chk("e42_rst", 32'(rst_out), 32'h0);
    chk("e42_ready", 32'(ready), 32'h1);

    // NCO rates over a 256-cycle window.
    step(4);
    cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      cnt0 += int'(ce_out[0]);
      cnt1 += int'(ce_out[1]);
      cnt2 += int'(ce_out[2]);
      cnt3 += int'(ce_out[3]);
    end
    chk("nco_inc64", 32'(cnt0), 32'd64);
    chk("nco_inc0", 32'(cnt1), 32'd0);
    chk("nco_inc255", 32'(cnt2), 32'd255);
    chk("nco_inc128", 32'(cnt3), 32'd128);

    // Single soft-reset pulse on channel 2.
    chan_rst_req = 4'b0100;
    step(1);
    chan_rst_req = '0;
    chk("soft_rst_start", 32'(rst_out), 32'h4);
    chk("soft_ce_silent0", 32'(ce_out[2]), 32'h0);
    chk("soft_ready", 32'(ready), 32'h1);
    for (int k = 1; k < PC; k++) begin
      step(1);
      chk("soft_rst_hold", 32'(rst_out), 32'h4);
      chk("soft_ce_silent", 32'(ce_out[2]), 32'h0);
    end
    step(1);
    chk("soft_rst_end", 32'(rst_out), 32'h0);

    // Re-request mid-pulse extends it.
    step(3);
    chan_rst_req = 4'b0100;
    step(1);
    chan_rst_req = '0;
    step(2);
    chan_rst_req = 4'b0100;
    step(1);
    chan_rst_req = '0;
    step(PC - 1);
    chk("soft_ext_hold", 32'(rst_out), 32'h4);
    step(1);
    chk("soft_ext_end", 32'(rst_out), 32'h0);

    // Lock loss in RUN; fall sampled at edge F.
    step(2);
    pll_locked = 1'b0;
    step(2);
    chk("loss_f1_rst", 32'(rst_out), 32'h0);
    chk("loss_f1_ready", 32'(ready), 32'h1);
    step(1);
    chk("loss_f2_rst", 32'(rst_out), 32'hF);
    chk("loss_f2_ready", 32'(ready), 32'h0);
    chk("loss_cnt1", 32'(lock_loss_cnt), 32'(LOSS_STEP));

    // Glitch during SETTLE restarts the lock count.
    step(4);
    pll_locked = 1'b1;
    step(10);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(18);
    chk("glitch_e30_rst", 32'(rst_out), 32'hF);
    step(1);
    chk("glitch_e31_rst", 32'(rst_out), 32'hE);
    chk("loss_cnt2", 32'(lock_loss_cnt), 32'(2 * LOSS_STEP));

    // Synchronous reset during RELEASE.
    step(3);
    reset = 1'b1;
    step(1);
    chk("mid_reset_rst", 32'(rst_out), 32'hF);
    chk("mid_reset_ready", 32'(ready), 32'h0);
    chk("mid_reset_ce", 32'(ce_out), 32'h0);
    chk("mid_reset_loss", 32'(lock_loss_cnt), 32'h0);
    step(1);
    reset = 1'b0;
    step(18);
    chk("restart_e17_rst", 32'(rst_out), 32'hF);
    step(1);
    chk("restart_e18_rst", 32'(rst_out), 32'hE);
    step(24);
    chk("restart_e42_rst", 32'(rst_out), 32'h0);
    chk("restart_e42_ready", 32'(ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/crg_seq.md
# crg_seq

Parametrised clock-enable and reset sequencer that sits directly after the top-level PLL in the clock/reset generator. It watches the PLL lock signal and holds every downstream domain in reset until lock has been stable. It then releases `CHANNELS` per-domain resets one after another, at a fixed stagger. Each channel also gets a fractional-NCO clock-enable, so slow rates such as audio or SPI are derived from `clk_sys` without extra PLL outputs.

## Interface
Parameters:
- `CHANNELS`, 4: number of reset/clock-enable channels, range 1..16.
- `ACC_W`, 32: NCO accumulator width per channel.
- `LOCK_CYCLES`, 1024: consecutive cycles of synchronised lock required before the first release, ≥1.
- `STAGGER`, 64: cycles between successive channel releases, ≥1.
- `PULSE_CYCLES`, 16: length of a per-channel soft reset, ≥1.

Ports:
- `clk_sys`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high.
- `pll_locked`  in  1  asynchronous PLL lock flag; double-flopped internally.
- `ce_inc`  in  CHANNELS*ACC_W  per-channel NCO increment; channel i is bits [i*ACC_W +: ACC_W].
- `chan_rst_req`  in  CHANNELS  per-channel soft-reset request, level-sampled.
- `rst_out`  out  CHANNELS  per-channel active-high reset.
- `ce_out`  out  CHANNELS  per-channel one-cycle clock-enable pulses.
- `ready`  out  1  high while all channels are released after a full sequence.
- `lock_loss_cnt`  out  8  lock-loss event counter (see Configuration).

## Operation
- `lock_s` is `pll_locked` after 2 flops.
- FSM states:
  - HOLD: all `rst_out`=1, `ready`=0. Moves to SETTLE with cnt=0 when `lock_s`=1.
  - SETTLE: cnt increments each cycle. On the edge where cnt==LOCK_CYCLES-1: clear `rst_out[0]`, set idx=1, reset cnt, enter RELEASE. If CHANNELS==1, enter RUN directly.
  - RELEASE: cnt counts STAGGER cycles. At STAGGER-1: clear `rst_out[idx]`, idx++, cnt=0. When the last channel is cleared, enter RUN and set `ready`=1 on the same edge.
  - RUN: steady state.
- Loss of lock: `lock_s`=0 in SETTLE, RELEASE or RUN sends the FSM to HOLD. All `rst_out`=1 and `ready`=0 from the next edge. A glitch during SETTLE restarts the count from 0.
- `reset`=1 forces HOLD, cnt=0, idx=0, all accumulators 0, and the synchroniser flops to 0. Reset mid-sequence behaves the same.
- Soft reset: in RUN only, `chan_rst_req[i]`=1 sets `rst_out[i]`=1 for PULSE_CYCLES cycles, starting at the next edge.
  - A request during an active pulse reloads the pulse counter.
  - `ready` stays 1 during soft resets.
  - Requests outside RUN are ignored.
- NCO, per channel while `rst_out[i]`=0:
  - {carry, acc_i} <= acc_i + inc_i, with ACC_W+1-bit sum, wrapping mod 2^ACC_W.
  - `ce_out[i]` <= carry.
  - Frequency = f_clk_sys * inc_i / 2^ACC_W.
  - inc=0 gives no pulses.
- NCO while `rst_out[i]`=1: acc_i=0 and `ce_out[i]`=0.
- `ce_inc` may change at any time; the new increment takes effect on the next accumulation.

## Timing
- Reset values: `rst_out`=all 1, `ce_out`=0, `ready`=0, `lock_loss_cnt`=0.
- Edge E0 is the first edge at which `pll_locked` is sampled high. With steady lock:
  - `rst_out[0]` falls at E(LOCK_CYCLES+2).
  - `rst_out[k]` falls at E(LOCK_CYCLES+2+k*STAGGER).
  - `ready` rises together with `rst_out[CHANNELS-1]`.
- A `pll_locked` fall sampled at edge F gives `rst_out` all 1 from F+2, with the FSM entering HOLD on that edge.
- First `ce_out[i]` pulse is no earlier than 1 cycle after `rst_out[i]` falls. `ce_out` is registered.

## Configuration
- `CRG_LOSS_CNT_EN` defined:
  - `lock_loss_cnt` increments, saturating at 255, on every transition into HOLD caused by `lock_s`=0 from SETTLE, RELEASE or RUN.
  - Cleared by `reset`.
- Undefined: `lock_loss_cnt` is tied to 0 and no counter logic is built.

## Test plan
- CHANNELS=4, LOCK_CYCLES=16, STAGGER=8; `pll_locked` rises and stays high -> `rst_out` bits fall at E18, E26, E34, E42; `ready`=1 at E42.
- Same configuration; `pll_locked` low for 3 cycles at E10 -> count restarts; release occurs 18 edges after lock is re-sampled.
- In RUN, drop `pll_locked` -> all `rst_out`=1 and `ready`=0 two edges later. With `CRG_LOSS_CNT_EN`, `lock_loss_cnt`=1.
- ACC_W=8, inc=64 -> `ce_out` pulses every 4th cycle. inc=0 -> no pulses. inc=255 -> 255 pulses per 256 cycles.
- In RUN, pulse `chan_rst_req[2]` for 1 cycle -> `rst_out[2]` high for exactly PULSE_CYCLES cycles and `ce_out[2]` silent during it. A re-request mid-pulse extends the pulse.
- Assert `reset` during RELEASE -> all outputs return to reset values next edge; the sequence restarts from HOLD.
